// File: rtl/seq_rec_sched.sv
// Round-robin scheduler sharing one serial 3-ones recognizer among N_REQ bit sources.
// Each grant flushes the recognizer, streams one burst, and credits matches to that channel.
module seq_rec_cnt_lane #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q;

   // A hit coinciding with a clear leaves the counter at 1, not 0.
   always_ff @(negedge clk or posedge reset) begin
      if (reset)                         cnt_q <= '0;
      else if (clr_i)                    cnt_q <= inc_i ? CNT_W'(1) : '0;
      else if (inc_i && (cnt_q != '1))   cnt_q <= cnt_q + 1'b1;
   end

   assign cnt_o = cnt_q;
endmodule

module seq_rec_sched #(
   parameter int N_REQ     = 4,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] d_in,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic             done,
   output logic [1:0]       done_id,
   output logic             rec_reset,
   output logic             rec_en,
   output logic             rec_d_in,
   input  logic             rec_match,
   output logic             hit,
   output logic [1:0]       hit_id,
   input  logic [1:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_out,
   input  logic             cnt_clr
);
   typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

   localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

   state_t           state_q, state_d;
   logic [1:0]       g_q, g_d, ptr_q, ptr_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [7:0]       bit_cnt_q, bit_cnt_d;
   logic             done_q, done_d, hit_q, hit_d;
   logic [1:0]       done_id_q, done_id_d, hit_id_q, hit_id_d;
   logic [N_REQ-1:0][CNT_W-1:0] match_cnt;

   logic       consume, found;
   logic [1:0] pick, idx;

   assign consume = (state_q == RUN) && req[g_q];

   // First set request at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      idx   = ptr_q;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      hit_d     = 1'b0;
      hit_id_d  = hit_id_q;
      case (state_q)
         IDLE: if (found) begin
            g_d          = pick;
            grant_d      = '0;
            grant_d[pick] = 1'b1;
            bit_cnt_d    = '0;
            state_d      = CLEAR;
         end
         CLEAR: state_d = RUN;
         RUN: begin
            if (consume) begin
               bit_cnt_d = bit_cnt_q + 8'd1;
               if (rec_match) begin
                  hit_d    = 1'b1;
                  hit_id_d = g_q;
               end
            end
            // A dropped request ends the burst without consuming a bit.
            if (!req[g_q] || (bit_cnt_q == LAST_CNT)) begin
               state_d   = IDLE;
               grant_d   = '0;
               done_d    = 1'b1;
               done_id_d = g_q;
               ptr_d     = g_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         g_q       <= '0;
         ptr_q     <= '0;
         grant_q   <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         hit_q     <= 1'b0;
         hit_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         hit_q     <= hit_d;
         hit_id_q  <= hit_id_d;
      end
   end

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      seq_rec_cnt_lane #(.CNT_W(CNT_W)) u_lane (
         .clk   (clk),
         .reset (reset),
         .clr_i (cnt_clr),
         .inc_i (hit_d && (g_q == 2'(i))),
         .cnt_o (match_cnt[i])
      );
   end

   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign hit       = hit_q;
   assign hit_id    = hit_id_q;
   assign rec_reset = (state_q == CLEAR);
   assign rec_en    = consume;
   assign rec_d_in  = (|grant_q) ? d_in[g_q] : 1'b0;
   assign cnt_out   = match_cnt[cnt_sel];
endmodule

// File: tb/tb_seq_rec_sched.sv
// Bench for seq_rec_sched: directed bursts; hit/done events checked by a scoreboard monitor.
module tb_seq_rec_sched;
   localparam int CNT_W = 2;

   logic             clk = 1'b1;
   logic             reset;
   logic [3:0]       req, d_in, grant;
   logic             busy, done, rec_reset, rec_en, rec_d_in, rec_match, hit, cnt_clr;
   logic [1:0]       done_id, hit_id, cnt_sel;
   logic [CNT_W-1:0] cnt_out;

   seq_rec_sched #(.N_REQ(4), .BURST_LEN(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .req(req), .d_in(d_in), .grant(grant), .busy(busy),
      .done(done), .done_id(done_id), .rec_reset(rec_reset), .rec_en(rec_en),
      .rec_d_in(rec_d_in), .rec_match(rec_match), .hit(hit), .hit_id(hit_id),
      .cnt_sel(cnt_sel), .cnt_out(cnt_out), .cnt_clr(cnt_clr)
   );

   always #10 clk = ~clk;

   // External recognizer: three consecutive ones, Mealy output.
   logic [1:0] h = 2'b00;
   assign rec_match = rec_en & rec_d_in & h[0] & h[1];
   always @(negedge clk) begin
      if (rec_reset)   h <= 2'b00;
      else if (rec_en) h <= {h[0], rec_d_in};
   end

   int cyc = 0;
   int en_cnt = 0;
   int vec_cnt = 0;
   int err_cnt = 0;
   always @(negedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #2;
      if (rec_en) en_cnt <= en_cnt + 1;
   end

   typedef struct {int id; int cyc;} ev_t;
   ev_t hq[$];
   ev_t dq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string nm);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
   endtask

   // Scoreboard monitor: every hit/done pulse must match the head of its queue.
   always @(posedge clk) begin
      ev_t e;
      if (hit) begin
         if (hq.size() == 0) unexpected("hit");
         else begin
            e = hq.pop_front();
            chk("hit_id", 32'(hit_id), 32'(e.id));
            chk("hit_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (done) begin
         if (dq.size() == 0) unexpected("done");
         else begin
            e = dq.pop_front();
            chk("done_id", 32'(done_id), 32'(e.id));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt(input int sel, input int exp);
      cnt_sel = 2'(sel);
      #1;
      chk($sformatf("match_cnt[%0d]", sel), 32'(cnt_out), 32'(exp));
   endtask

   // bits/hits: bit j of the burst is index j-1. Returns one cycle after done.
   task automatic run_burst(input logic [3:0] mask, input int ch, input logic [7:0] bits,
                            input logic [7:0] hits, input int n, input bit drop, input int clr_at);
      int e, d, en0;
      e = cyc + 1;
      d = drop ? e + 2 + n : e + 1 + n;
      for (int j = 1; j <= n; j++)
         if (hits[j-1]) hq.push_back('{ch, e + 1 + j});
      dq.push_back('{ch, d});
      d_in = 4'b0000;
      req  = mask;
      tick();
      chk("grant", 32'(grant), 32'(4'b0001 << ch));
      chk("clear_state", 32'({busy, rec_reset, rec_en}), 32'(3'b110));
      en0 = en_cnt;
      tick();
      for (int j = 1; j <= n; j++) begin
         d_in[ch] = bits[j-1];
         cnt_clr  = (j == clr_at);
         tick();
      end
      cnt_clr = 1'b0;
      if (drop) begin
         req  = 4'b0000;
         d_in = 4'b0000;
         tick();
      end
      req  = 4'b0000;
      d_in = 4'b0000;
      tick();
      chk("rec_en_cycles", 32'(en_cnt - en0), 32'(n));
      chk("idle_after", 32'({busy, grant}), 32'(0));
   endtask

   initial begin
      int e;
      reset = 1'b1; req = '0; d_in = '0; cnt_sel = '0; cnt_clr = 1'b0;
      tick();
      chk("reset_ctrl", 32'({grant, busy, done, hit, rec_reset, rec_en}), 32'(0));
      chk("reset_ids", 32'({done_id, hit_id}), 32'(0));
      check_cnt(0, 0);
      reset = 1'b0;
      tick();

      // Single burst: 1,1,1,1,0,1,1,1 -> hits on bits 3,4,8.
      run_burst(4'b0001, 0, 8'b1110_1111, 8'b1000_1100, 8, 1'b0, 0);
      check_cnt(0, 3);

      // History flush: ch0 ends on 1,1; ch1 begins with 1,0 and must not hit.
      run_burst(4'b0001, 0, 8'b1100_0000, 8'b0000_0000, 8, 1'b0, 0);
      run_burst(4'b0010, 1, 8'b0000_0001, 8'b0000_0000, 8, 1'b0, 0);
      check_cnt(1, 0);

      // Standalone clear, then saturation: 6 hits on a 2-bit counter.
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check_cnt(0, 0);
      run_burst(4'b0001, 0, 8'b1111_1111, 8'b1111_1100, 8, 1'b0, 0);
      check_cnt(0, 3);

      // Early drop after three ones on ch2.
      run_burst(4'b0100, 2, 8'b0000_0111, 8'b0000_0100, 3, 1'b1, 0);
      check_cnt(2, 1);

      // Pointer now at ch3: it wins over ch0 and ch1.
      run_burst(4'b1011, 3, 8'b0000_0000, 8'b0000_0000, 8, 1'b0, 0);

      // Clear coincident with a ch0 hit on bit 5.
      run_burst(4'b0001, 0, 8'b0001_1100, 8'b0001_0000, 8, 1'b0, 5);
      check_cnt(0, 1);
      check_cnt(2, 0);

      // Reset in the middle of a ch1 burst, as bit 4 is presented.
      e = cyc + 1;
      hq.push_back('{1, e + 4});
      req = 4'b0010;
      tick();
      tick();
      for (int j = 1; j <= 3; j++) begin
         d_in[1] = 1'b1;
         tick();
      end
      reset = 1'b1;
      #1;
      chk("midrun_reset", 32'({grant, busy, done}), 32'(0));
      check_cnt(0, 0);
      check_cnt(1, 0);
      req = '0; d_in = '0;
      tick();
      reset = 1'b0;
      tick();

      // Round robin with all requests held: order 0,1,2,3,0, ten cycles apart.
      e = cyc + 1;
      for (int k = 0; k < 5; k++) dq.push_back('{k % 4, e + 9 + 10 * k});
      req = 4'b1111;
      for (int k = 0; k < 50; k++) tick();
      req = 4'b0000;
      for (int k = 0; k < 4; k++) tick();

      chk("hit_queue_drained", 32'(hq.size()), 32'(0));
      chk("done_queue_drained", 32'(dq.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/seq_rec_sched.md
# seq_rec_sched

Round-robin scheduler that time-shares one external serial sequence recognizer (the 3-consecutive-1s shift-register recognizer, Mealy output) among `N_REQ` serial bit sources. It grants one requester at a time and flushes the recognizer's history before each burst, so bits from different channels never combine. While the burst runs it steers the granted source's bit stream into the recognizer and drives its enable. It attributes every match to the granted channel and keeps a saturating per-channel match count for readback.

## Interface
- `N_REQ`, 4: number of requesters. Fixed at 4 in this revision; ID fields are 2 bits.
- `BURST_LEN`, 8: maximum bits consumed per grant. Must be ≥1 and ≤255.
- `CNT_W`, 8: width of each per-channel match counter.
- `clk`  in  1  clock; all state updates occur on the falling edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  per-channel burst request, level.
- `d_in`  in  N_REQ  per-channel serial data bit.
- `grant`  out  N_REQ  one-hot grant, registered.
- `busy`  out  1  high in CLEAR or RUN.
- `done`  out  1  one-cycle pulse after a burst ends.
- `done_id`  out  2  channel whose burst ended; valid with `done`.
- `rec_reset`  out  1  recognizer synchronous clear; high in CLEAR.
- `rec_en`  out  1  recognizer enable; equals RUN && `req[g]`.
- `rec_d_in`  out  1  equals `d_in[g]` while granted, else 0.
- `rec_match`  in  1  recognizer Mealy output.
- `hit`  out  1  registered one-cycle pulse per consumed bit on which `rec_match` was 1.
- `hit_id`  out  2  channel of `hit`.
- `cnt_sel`  in  2  counter readback select.
- `cnt_out`  out  CNT_W  `match_cnt[cnt_sel]`, combinational read.
- `cnt_clr`  in  1  clears all match counters at the next falling edge.

## Operation
- Notation: `g` = granted channel index; `ptr` = round-robin start pointer; `bit_cnt` = bits consumed in the current burst, width 8.
- States:
  - IDLE
    - If no `req` is set, the state holds.
    - Otherwise, search from `ptr` upward (mod 4) for the first set `req`. Set `grant`/`g` to it, clear `bit_cnt`, and go to CLEAR.
  - CLEAR
    - `rec_reset`=1 and `rec_en`=0 for exactly one cycle, which flushes the recognizer history.
    - Next state is RUN unconditionally, even if `req[g]` has dropped.
  - RUN
    - Each falling edge with `req[g]`=1 consumes one bit and increments `bit_cnt`.
    - If `rec_match`=1 at that edge: `hit`=1, `hit_id`=g, and `match_cnt[g]` increments.
    - The burst ends at the edge that consumes bit `BURST_LEN`, or at any edge where `req[g]`=0. A dropped request consumes no bit at that edge.
    - On end: go to IDLE; clear `grant`; pulse `done` with `done_id`=g; set `ptr`=(g+1) mod 4.
- `match_cnt` arithmetic:
  - Counters are unsigned and saturate at 2^CNT_W−1; they never wrap.
  - If `cnt_clr` and a hit occur on the same edge, the hit channel's counter becomes 1 and all other counters become 0.
- Reset values:
  - state=IDLE, `ptr`=0, `grant`=0, `bit_cnt`=0, all `match_cnt`=0.
  - `busy`=0, `done`=0, `done_id`=0, `hit`=0, `hit_id`=0, `rec_reset`=0, `rec_en`=0.
- Reset mid-burst aborts immediately: no `done`, and the counters clear. The recognizer is re-flushed by CLEAR on the next grant.
- Changes to `req` of non-granted channels have no effect during a burst.

## Timing
- Request to first consumed bit: the IDLE→CLEAR edge, then the CLEAR→RUN edge. The first bit is consumed at the third falling edge after `req` is seen in IDLE.
- A full burst occupies BURST_LEN RUN cycles. Back-to-back grant overhead is 2 cycles (IDLE + CLEAR).
- `hit` is registered at the consuming edge and is visible for the following cycle. `rec_match` is sampled at the same edge the recognizer shifts.
- `done` is high during the first IDLE cycle after a burst. A new grant may be taken at the edge ending that cycle.
- `rec_en`, `rec_d_in` and `cnt_out` are combinational from registered state and inputs.

## Test plan
- Single burst:
  - Stimulus: `req`=0001 held; ch0 bits 1,1,1,1,0,1,1,1.
  - Required: `hit` after bits 3, 4 and 8; `match_cnt[0]`=3; `done`, `done_id`=0 after 8 RUN cycles.
- History flush:
  - Stimulus: ch0 burst ends with bits 1,1; ch1 burst starts with 1,0,….
  - Required: `rec_reset` high between the bursts; no `hit` on ch1 bit 1; `match_cnt[1]`=0.
- Round robin:
  - Stimulus: `req`=1111 held for 5 bursts.
  - Required: grant order 0,1,2,3,0; IDLE→CLEAR gap of 2 cycles between bursts.
- Early drop:
  - Stimulus: ch2 drops `req` after 3 consumed bits of 1,1,1.
  - Required: 1 hit; `done_id`=2; exactly 3 `rec_en` cycles in RUN; next grant search starts at ch3.
- Saturation and clear:
  - Stimulus: `CNT_W`=2; ch0 all-ones burst of 8 bits (6 hits).
  - Required: `match_cnt[0]`=3.
  - Then `cnt_clr` coincident with a ch0 hit → `match_cnt[0]`=1.
- Reset mid-RUN:
  - Stimulus: assert `reset` at bit 4 of a burst.
  - Required: `grant`=0, `busy`=0 and counters=0 immediately; no `done`.
